// File: rtl/addsub_pkg.sv
// Shared types for the two-requester add/subtract arbiter and its datapath.
package addsub_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic       req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_t;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic calc_ovf(input nibble_t a, input nibble_t b2, input nibble_t s);
    return (a[3] == b2[3]) && (s[3] != a[3]);
  endfunction

endpackage

// File: rtl/adder_subtractor.sv
// 4-bit ripple-carry adder/subtractor; m=1 inverts B and injects carry-in for A-B.
module adder_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;
  logic [3:0] b2;

  assign c[0] = m;
  assign b2   = b ^ {4{m}};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign s[gi]   = a[gi] ^ b2[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b2[gi]) | (c[gi] & (a[gi] ^ b2[gi]));
    end
  endgenerate

  assign cout = c[4];

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one adder_subtractor; winner's result lands in a
// one-entry output buffer with valid/ready backpressure.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_m,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_m,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_sum,
  output logic       rsp_cout,
  output logic       rsp_ovf,
  output logic       rsp_id
);

  rsp_state_t state_reg;
  req_id_t    ptr_reg;
  req_id_t    id_reg;
  nibble_t    sum_reg;
  logic       cout_reg;
  logic       ovf_reg;

  req_id_t    gnt_id;
  logic       gnt_any;
  logic       free;
  logic       accept;
  nibble_t    op_a, op_b, op_b2, alu_s;
  logic       op_m, alu_cout;

  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = REQ0;
    if (req0_valid && req1_valid)
      gnt_id = (RR && (ptr_reg == REQ1)) ? REQ1 : REQ0;
    else if (req1_valid)
      gnt_id = REQ1;
  end

  // Readiness is gated by rst_n so nothing is handshaken while reset is held.
  assign free       = (state_reg == RSP_EMPTY) || rsp_ready;
  assign accept     = gnt_any && free && rst_n;
  assign req0_ready = accept && (gnt_id == REQ0);
  assign req1_ready = accept && (gnt_id == REQ1);

  assign op_a  = (gnt_id == REQ1) ? req1_a : req0_a;
  assign op_b  = (gnt_id == REQ1) ? req1_b : req0_b;
  assign op_m  = (gnt_id == REQ1) ? req1_m : req0_m;
  assign op_b2 = op_b ^ {4{op_m}};

  adder_subtractor u_alu (
    .a   (op_a),
    .b   (op_b),
    .m   (op_m),
    .s   (alu_s),
    .cout(alu_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RSP_EMPTY;
      ptr_reg   <= REQ0;
      id_reg    <= REQ0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        // Covers EMPTY->FULL and the back-to-back FULL->FULL refill.
        state_reg <= RSP_FULL;
        sum_reg   <= alu_s;
        cout_reg  <= alu_cout;
        ovf_reg   <= calc_ovf(op_a, op_b2, alu_s);
        id_reg    <= gnt_id;
        if (RR) ptr_reg <= ~gnt_id;
      end else if (state_reg == RSP_FULL && rsp_ready) begin
        state_reg <= RSP_EMPTY;
      end
    end
  end

  assign rsp_valid = (state_reg == RSP_FULL);
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = cout_reg;
  assign rsp_ovf   = ovf_reg;
  assign rsp_id    = id_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench: single-op vector table plus arbitration, backpressure and reset sequences.
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_m, req1_m, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;

  logic       r0_ready, r1_ready, rv, rc, ro, rid;
  logic [3:0] rs;
  logic       f0_ready, f1_ready, fv, fc, fo, fid;
  logic [3:0] fs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
    .req1_valid(req1_valid), .req1_ready(r1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
    .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_sum(rs), .rsp_cout(rc), .rsp_ovf(ro), .rsp_id(rid)
  );

  addsub_arbiter #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
    .req1_valid(req1_valid), .req1_ready(f1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
    .rsp_valid(fv), .rsp_ready(rsp_ready), .rsp_sum(fs), .rsp_cout(fc), .rsp_ovf(fo), .rsp_id(fid)
  );

  typedef struct {
    logic       id;
    logic [3:0] a, b;
    logic       m;
    logic [3:0] sum;
    logic       cout, ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; rsp_ready = 1; req0_m = 0; req1_m = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    idle_inputs();

    vecs[0] = '{1'b0, 4'd3, 4'd5, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'd5, 4'd3, 1'b1, 4'd2,  1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'd7, 4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'd8, 4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
    vecs[5] = '{1'b1, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};

    #12;
    chk("reset_valid", {7'd0, rv}, 8'd0);
    chk("reset_sum", {4'd0, rs}, 8'd0);
    chk("reset_ready0_held", {7'd0, r0_ready}, 8'd0);
    @(negedge clk); rst_n = 1;

    // Idle in EMPTY with rsp_ready low: nothing happens
    rsp_ready = 0;
    tick();
    @(negedge clk);
    chk("idle_valid", {7'd0, rv}, 8'd0);
    rsp_ready = 1;

    foreach (vecs[i]) begin
      tick();
      if (vecs[i].id) begin
        req1_valid = 1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_m = vecs[i].m;
      end else begin
        req0_valid = 1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_m = vecs[i].m;
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {6'd0, r1_ready, r0_ready}, vecs[i].id ? 8'd2 : 8'd1);
      tick();
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {7'd0, rv}, 8'd1);
      chk($sformatf("v%0d_sum", i), {4'd0, rs}, {4'd0, vecs[i].sum});
      chk($sformatf("v%0d_cout", i), {7'd0, rc}, {7'd0, vecs[i].cout});
      chk($sformatf("v%0d_ovf", i), {7'd0, ro}, {7'd0, vecs[i].ovf});
      chk($sformatf("v%0d_id", i), {7'd0, rid}, {7'd0, vecs[i].id});
    end
    tick();  // drain, ptr is now 0 for RR (last grant went to 1)

    // Sustained dual requests: RR alternates, fixed priority stays on 0
    req0_a = 4'd1; req0_b = 4'd1; req0_m = 0;
    req1_a = 4'd2; req1_b = 4'd2; req1_m = 0;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr%0d_valid", i), {7'd0, rv}, 8'd1);
      chk($sformatf("rr%0d_id", i), {7'd0, rid}, {7'd0, 1'(i % 2)});
      chk($sformatf("rr%0d_sum", i), {4'd0, rs}, (i % 2) ? 8'd4 : 8'd2);
      chk($sformatf("fp%0d_id", i), {7'd0, fid}, 8'd0);
      chk($sformatf("fp%0d_valid", i), {7'd0, fv}, 8'd1);
    end
    idle_inputs();
    tick();

    // Backpressure: one accept, then hold rsp_ready low for 3 cycles
    rsp_ready = 0;
    req0_valid = 1; req0_a = 4'd4; req0_b = 4'd4; req0_m = 0;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 4'd6; req1_b = 4'd1; req1_m = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_readys", i), {6'd0, r1_ready, r0_ready}, 8'd0);
      chk($sformatf("bp%0d_sum", i), {4'd0, rs}, 8'd8);
      chk($sformatf("bp%0d_valid", i), {7'd0, rv}, 8'd1);
      chk($sformatf("bp%0d_id", i), {7'd0, rid}, 8'd0);
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_ready1", {7'd0, r1_ready}, 8'd1);
    tick();
    req1_valid = 0;
    @(negedge clk);
    chk("b2b_valid", {7'd0, rv}, 8'd1);
    chk("b2b_sum", {4'd0, rs}, 8'd7);
    chk("b2b_id", {7'd0, rid}, 8'd1);
    tick();
    @(negedge clk);
    chk("drain_empty", {7'd0, rv}, 8'd0);

    // Reset while FULL with ptr pointing at requester 1
    rsp_ready = 0;
    req0_valid = 1; req0_a = 4'd2; req0_b = 4'd3; req0_m = 0;
    tick();
    chk("pre_reset_full", {7'd0, rv}, 8'd1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_valid", {7'd0, rv}, 8'd0);
    chk("async_reset_sum", {4'd0, rs}, 8'd0);
    chk("async_reset_ready0", {7'd0, r0_ready}, 8'd0);
    @(negedge clk); rst_n = 1;
    rsp_ready = 1;
    req1_valid = 1; req1_a = 4'd1; req1_b = 4'd0; req1_m = 0;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("post_reset_tie_id", {7'd0, rid}, 8'd0);
    chk("post_reset_tie_sum", {4'd0, rs}, 8'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
